regfile_sb: RTL and testbench

- Parametrised register file for the pipelined MIPS datapath.
- Two asynchronous read ports and one clocked write port; registers reset to their own index.
- Integrated pending-write scoreboard that lets issue logic detect RAW hazards (pending flag per read) and WAW hazards (issue stall).
- Sits between decode/issue (read, issue) and writeback (write/clear).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 60 ++++++
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the regfile_sb register file
package regfile_pkg;

  localparam int DEFAULT_DW    = 16;
  localparam int DEFAULT_DEPTH = 8;

  // Address width for a register count; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write bits, WAW issue stall and pending counter
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  DEPTH    = DEFAULT_DEPTH,
  parameter int  ZERO_REG = 0,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          rd_pend1,
  output logic          rd_pend2,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  output logic          iss_stall,
  output logic [AW:0]   pend_cnt
);

  localparam int CW = AW + 1;

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic             iss_zero;
  logic             wr_hit;
  logic             set_ok;
  logic             set_eff;
  logic             clr_eff;

  assign iss_zero  = (ZERO_REG != 0) && (iss_addr == '0);
  assign wr_hit    = wr_en && (wr_addr == iss_addr);
  // A writeback retiring the same register frees it for the new owner this edge.
  assign iss_stall = iss_en && pend[iss_addr] && !wr_hit && !iss_zero;
  assign set_ok    = iss_en && !iss_stall && !iss_zero;
  assign set_eff   = set_ok && !pend[iss_addr];
  assign clr_eff   = wr_en && pend[wr_addr] && !(set_ok && wr_hit);

  assign rd_pend1 = pend[rd_addr1];
  assign rd_pend2 = pend[rd_addr2];

  always_comb begin
    pend_nxt = pend;
    if (wr_en)  pend_nxt[wr_addr]  = 1'b0;
    if (set_ok) pend_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= pend_cnt + CW'(set_eff) - CW'(clr_eff);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with pending-write scoreboard (REGFILE_BYPASS_EN adds write-to-read forwarding)
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  DW       = DEFAULT_DW,
  parameter int  DEPTH    = DEFAULT_DEPTH,
  parameter int  ZERO_REG = 0,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic          rd_pend1,
  output logic          rd_pend2,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  output logic          iss_stall,
  output logic [AW:0]   pend_cnt
);

  logic [DW-1:0] rf [DEPTH];
  logic          sb_pend1;
  logic          sb_pend2;
  logic          wr_zero;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rd_pend1  (sb_pend1),
    .rd_pend2  (sb_pend2),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_stall (iss_stall),
    .pend_cnt  (pend_cnt)
  );

  // Each register resets to its own index, which makes r0 zero as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= DW'(i);
    end else if (wr_en && !wr_zero) begin
      rf[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = rf[rd_addr1];
    rd_pend1 = sb_pend1;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      rd_pend1 = 1'b0;
    end
`endif
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
      rd_data1 = '0;
      rd_pend1 = 1'b0;
    end
  end

  always_comb begin
    rd_data2 = rf[rd_addr2];
    rd_pend2 = sb_pend2;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
      rd_pend2 = 1'b0;
    end
`endif
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
      rd_data2 = '0;
      rd_pend2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed vector bench for regfile_sb (plain and ZERO_REG instances)
module tb_regfile_sb;

  localparam int DW  = 16;
  localparam int AW  = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, iss_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en, iss_en;

  logic [DW-1:0] rd_data1, rd_data2, z_rd_data1, z_rd_data2;
  logic          rd_pend1, rd_pend2, z_rd_pend1, z_rd_pend2;
  logic          iss_stall, z_iss_stall;
  logic [AW:0]   pend_cnt, z_pend_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DW(DW), .DEPTH(8), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_pend1(rd_pend1), .rd_pend2(rd_pend2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_stall(iss_stall), .pend_cnt(pend_cnt)
  );

  regfile_sb #(.DW(DW), .DEPTH(8), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
    .rd_pend1(z_rd_pend1), .rd_pend2(z_rd_pend2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_stall(z_iss_stall), .pend_cnt(z_pend_cnt)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ie;
    logic [AW-1:0] ia;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] d1, d2;
    logic          p1, p2, st;
    logic [AW:0]   cnt;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(logic we, logic [AW-1:0] wa, logic [DW-1:0] wd,
                              logic ie, logic [AW-1:0] ia,
                              logic [AW-1:0] a1, logic [AW-1:0] a2,
                              logic [DW-1:0] d1, logic [DW-1:0] d2,
                              logic p1, logic p2, logic st, logic [AW:0] cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.a1 = a1; v.a2 = a2; v.d1 = d1; v.d2 = d2;
    v.p1 = p1; v.p2 = p2; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    rd_addr1 = a1; rd_addr2 = a2;
  endtask

  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic ie, input logic [AW-1:0] ia,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    @(posedge clk);
    #1;
    drive(we, wa, wd, ie, ia, a1, a2);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Expected outputs are sampled before the edge that commits each vector.
    vt[0]  = mk(0, 0, 16'h0,    0, 0, 5, 7, 16'h0005, 16'h0007, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 16'h0,    1, 3, 3, 4, 16'h0003, 16'h0004, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 16'h0,    0, 0, 3, 3, 16'h0003, 16'h0003, 1, 1, 0, 1);
    vt[3]  = mk(1, 3, 16'hBEEF, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 0, 0, 1);
    vt[4]  = mk(0, 0, 16'h0,    0, 0, 3, 3, 16'hBEEF, 16'hBEEF, 0, 0, 0, 0);
    vt[5]  = mk(0, 0, 16'h0,    1, 4, 4, 2, 16'h0004, 16'h0002, 0, 0, 0, 0);
    vt[6]  = mk(0, 0, 16'h0,    1, 4, 4, 2, 16'h0004, 16'h0002, 1, 0, 1, 1);
    vt[7]  = mk(1, 4, 16'h1111, 1, 4, 1, 2, 16'h0001, 16'h0002, 0, 0, 0, 1);
    vt[8]  = mk(0, 0, 16'h0,    1, 2, 4, 4, 16'h1111, 16'h1111, 1, 1, 0, 1);
    vt[9]  = mk(1, 2, 16'h2222, 1, 1, 1, 5, 16'h0001, 16'h0005, 0, 0, 0, 2);
    vt[10] = mk(0, 0, 16'h0,    0, 0, 1, 2, 16'h0001, 16'h2222, 1, 0, 0, 2);
    vt[11] = mk(1, 5, 16'h5555, 0, 0, 6, 7, 16'h0006, 16'h0007, 0, 0, 0, 2);
    vt[12] = mk(0, 0, 16'h0,    0, 0, 5, 5, 16'h5555, 16'h5555, 0, 0, 0, 2);
    vt[13] = mk(1, 4, 16'h4444, 0, 0, 1, 2, 16'h0001, 16'h2222, 1, 0, 0, 2);
    vt[14] = mk(0, 0, 16'h0,    0, 0, 4, 1, 16'h4444, 16'h0001, 0, 1, 0, 1);
    vt[15] = mk(0, 0, 16'h0,    1, 1, 1, 4, 16'h0001, 16'h4444, 1, 0, 1, 1);

    do_reset();

    for (int i = 0; i < 16; i++) begin
      step(vt[i].we, vt[i].wa, vt[i].wd, vt[i].ie, vt[i].ia, vt[i].a1, vt[i].a2);
      chk($sformatf("v%0d rd_data1", i), 32'(rd_data1), 32'(vt[i].d1));
      chk($sformatf("v%0d rd_data2", i), 32'(rd_data2), 32'(vt[i].d2));
      chk($sformatf("v%0d rd_pend1", i), 32'(rd_pend1), 32'(vt[i].p1));
      chk($sformatf("v%0d rd_pend2", i), 32'(rd_pend2), 32'(vt[i].p2));
      chk($sformatf("v%0d iss_stall", i), 32'(iss_stall), 32'(vt[i].st));
      chk($sformatf("v%0d pend_cnt", i), 32'(pend_cnt), 32'(vt[i].cnt));
    end

    // Write-cycle visibility of a pending register (r1), with and without forwarding.
    step(1, 1, 16'hABCD, 0, 0, 1, 1);
    chk("wcyc rd_data1", 32'(rd_data1), BYP ? 32'hABCD : 32'h0001);
    chk("wcyc rd_pend1", 32'(rd_pend1), BYP ? 32'h0 : 32'h1);
    step(0, 0, 16'h0, 0, 0, 1, 4);
    chk("postw rd_data1", 32'(rd_data1), 32'hABCD);
    chk("postw rd_pend1", 32'(rd_pend1), 32'h0);
    chk("postw pend_cnt", 32'(pend_cnt), 32'h0);

    // Same-edge write and issue of non-pending r6: data lands, set wins.
    step(1, 6, 16'h6666, 1, 6, 0, 0);
    step(0, 0, 16'h0, 0, 0, 6, 2);
    chk("setclr6 rd_data1", 32'(rd_data1), 32'h6666);
    chk("setclr6 rd_pend1", 32'(rd_pend1), 32'h1);
    chk("setclr6 pend_cnt", 32'(pend_cnt), 32'h1);

    // Asynchronous reset in mid-cycle, then reset holding off a write and issue.
    #2 rst_n = 1'b0;
    #1;
    chk("arst pend_cnt", 32'(pend_cnt), 32'h0);
    chk("arst rd_data1", 32'(rd_data1), 32'h0006);
    chk("arst rd_pend1", 32'(rd_pend1), 32'h0);
    drive(1, 6, 16'h9999, 1, 2, 6, 2);
    @(posedge clk);
    #1;
    drive(0, 0, 16'h0, 0, 0, 6, 2);
    #1;
    chk("rsthold rd_data1", 32'(rd_data1), 32'h0006);
    chk("rsthold rd_pend2", 32'(rd_pend2), 32'h0);
    chk("rsthold pend_cnt", 32'(pend_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ZERO_REG instance.
    do_reset();
    step(1, 0, 16'h1234, 0, 0, 0, 0);
    chk("z wr0 rd_data1", 32'(z_rd_data1), 32'h0);
    chk("z wr0 rd_pend1", 32'(z_rd_pend1), 32'h0);
    step(0, 0, 16'h0, 1, 0, 0, 0);
    chk("z iss0 stall", 32'(z_iss_stall), 32'h0);
    step(0, 0, 16'h0, 0, 0, 0, 0);
    chk("z after rd_data1", 32'(z_rd_data1), 32'h0);
    chk("z after rd_pend1", 32'(z_rd_pend1), 32'h0);
    chk("z after pend_cnt", 32'(z_pend_cnt), 32'h0);
    for (int r = 1; r < 8; r++) begin
      step(0, 0, 16'h0, 1, 3'(r), 0, 0);
      chk($sformatf("z iss%0d stall", r), 32'(z_iss_stall), 32'h0);
    end
    step(0, 0, 16'h0, 1, 7, 7, 0);
    chk("z full stall", 32'(z_iss_stall), 32'h1);
    chk("z full pend_cnt", 32'(z_pend_cnt), 32'h7);
    chk("z full rd_pend1", 32'(z_rd_pend1), 32'h1);
    chk("z full rd_pend2", 32'(z_rd_pend2), 32'h0);
    step(0, 0, 16'h0, 1, 0, 0, 5);
    chk("z full iss0 stall", 32'(z_iss_stall), 32'h0);
    step(0, 0, 16'h0, 0, 0, 0, 5);
    chk("z final pend_cnt", 32'(z_pend_cnt), 32'h7);
    chk("z final rd_pend2", 32'(z_rd_pend2), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
